// File: rtl/booth_r4_mac_unit.sv
// Iterative signed radix-4 Booth multiplier with add and multiply-accumulate modes.
// One Booth digit is retired per cycle; valid/ready handshakes on both sides.
module booth_r4_mac_unit #(
  parameter int INWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [INWIDTH-1:0]     a,
  input  logic [INWIDTH-1:0]     b,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*INWIDTH-1:0]   result,
  output logic [2*INWIDTH-1:0]   acc,
  output logic                   busy
);
  localparam int OUTWIDTH = 2 * INWIDTH;
  localparam int ITER     = INWIDTH / 2;
  localparam int CNT_W    = $clog2(ITER) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic signed [OUTWIDTH-1:0]  a_sh_q, a_sh_d;
  logic signed [INWIDTH:0]     b_sh_q, b_sh_d;
  logic signed [OUTWIDTH-1:0]  pp_q, pp_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        mac_q, mac_d;
  logic signed [OUTWIDTH-1:0]  result_q, result_d;
  logic signed [OUTWIDTH-1:0]  acc_q, acc_d;

  logic signed [OUTWIDTH-1:0]  term;
  logic signed [OUTWIDTH-1:0]  pp_sum;
  logic                        last_digit;

  function automatic logic signed [OUTWIDTH-1:0] sext(input logic [INWIDTH-1:0] v);
    return {{(OUTWIDTH-INWIDTH){v[INWIDTH-1]}}, v};
  endfunction

  // b_sh_q carries the multiplier with an appended b[-1]=0, so the low three
  // bits are always the current Booth triplet; a_sh_q is the pre-shifted a.
  always_comb begin
    term = '0;
    case (b_sh_q[2:0])
      3'b001, 3'b010: term = a_sh_q;
      3'b011:         term = a_sh_q <<< 1;
      3'b100:         term = -(a_sh_q <<< 1);
      3'b101, 3'b110: term = -a_sh_q;
      default:        term = '0;
    endcase
  end

  assign pp_sum     = pp_q + term;
  assign last_digit = (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    pp_d     = pp_q;
    cnt_d    = cnt_q;
    mac_d    = mac_q;
    result_d = result_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            2'b01: begin
              result_d = sext(a) + sext(b);
              state_d  = S_DONE;
            end
            2'b10, 2'b11: begin
              a_sh_d  = sext(a);
              b_sh_d  = {b, 1'b0};
              pp_d    = '0;
              cnt_d   = '0;
              mac_d   = op[0];
              state_d = S_CALC;
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        pp_d   = pp_sum;
        a_sh_d = a_sh_q <<< 2;
        b_sh_d = b_sh_q >>> 2;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_digit) begin
          state_d = S_DONE;
          if (mac_q) begin
            result_d = acc_q + pp_sum;
            acc_d    = acc_q + pp_sum;
          end else begin
            result_d = pp_sum;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A clear overrides any accumulator update landing on the same edge.
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      pp_q     <= '0;
      cnt_q    <= '0;
      mac_q    <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      pp_q     <= pp_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_booth_r4_mac_unit.sv
// Bench for booth_r4_mac_unit: directed cases plus randomized ops against a
// plain-arithmetic model of add, multiply and the accumulator.
module tb_booth_r4_mac_unit;
  localparam int W  = 16;
  localparam int OW = 2 * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          acc_clr;
  logic          out_valid, out_ready;
  logic [OW-1:0] result, acc;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [OW-1:0] m_acc = '0;

  booth_r4_mac_unit #(.INWIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=hung required=finished");
    $fatal(1);
  end

  function automatic logic [OW-1:0] m_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] m_add(input logic [W-1:0] x, input logic [W-1:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
    return s[OW-1:0];
  endfunction

  // Reference: applies the accept-edge clear, then the op's effect on acc.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic clr, output logic [OW-1:0] exp_res);
    if (clr) m_acc = '0;
    case (o)
      2'b01:   exp_res = m_add(x, y);
      2'b10:   exp_res = m_mul(x, y);
      default: begin exp_res = m_acc + m_mul(x, y); m_acc = exp_res; end
    endcase
  endtask

  // Presents one request, scrambles the inputs after accept, waits for out_valid.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic clr, output int lat, output logic [OW-1:0] res);
    in_valid = 1'b1; op = o; a = x; b = y; acc_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
    op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    acc_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (result !== '0 || acc !== '0) begin
      n_err++; $display("FAIL reset_data: result=%h acc=%h required 0/0", result, acc);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_directed();
    logic [W-1:0]  xs [3] = '{16'd3, 16'h8000, 16'h7FFF};
    logic [W-1:0]  ys [3] = '{16'hFFFB, 16'h8000, 16'h8000};
    logic [OW-1:0] ex [3] = '{32'hFFFFFFF1, 32'h40000000, 32'hC0008000};
    int lat;
    logic [OW-1:0] res;
    for (int i = 0; i < 3; i++) begin
      issue(2'b10, xs[i], ys[i], 1'b0, lat, res);
      n_cmp++;
      if (lat !== 9) begin n_err++; $display("FAIL mult_lat[%0d]: latency=%0d required 9", i, lat); end
      n_cmp++;
      if (res !== ex[i]) begin n_err++; $display("FAIL mult_res[%0d]: result=%h required %h", i, res, ex[i]); end
      n_cmp++;
      if (acc !== m_acc) begin n_err++; $display("FAIL mult_acc[%0d]: acc=%h required %h", i, acc, m_acc); end
      pop();
    end
  endtask

  task automatic test_add_directed();
    logic [W-1:0]  xs [2] = '{16'h7FFF, 16'hFFFF};
    logic [OW-1:0] ex [2] = '{32'h0000FFFE, 32'hFFFFFFFE};
    int lat;
    logic [OW-1:0] res;
    for (int i = 0; i < 2; i++) begin
      issue(2'b01, xs[i], xs[i], 1'b0, lat, res);
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL add_lat[%0d]: latency=%0d required 1", i, lat); end
      n_cmp++;
      if (res !== ex[i]) begin n_err++; $display("FAIL add_res[%0d]: result=%h required %h", i, res, ex[i]); end
      pop();
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  edge_vals [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [1:0]    o;
    logic [W-1:0]  x, y;
    logic          clr;
    logic [OW-1:0] exp_res, res;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(1, 3));
      x   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      y   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      issue(o, x, y, clr, lat, res);
      model_op(o, x, y, clr, exp_res);
      n_cmp++;
      if (lat !== ((o == 2'b01) ? 1 : 9)) begin
        n_err++; $display("FAIL rnd_lat[%0d]: op=%0d latency=%0d", i, o, lat);
      end
      n_cmp++;
      if (res !== exp_res) begin
        n_err++; $display("FAIL rnd_res[%0d]: op=%0d a=%h b=%h result=%h required %h", i, o, x, y, res, exp_res);
      end
      n_cmp++;
      if (acc !== m_acc) begin n_err++; $display("FAIL rnd_acc[%0d]: acc=%h required %h", i, acc, m_acc); end
      pop();
    end
  endtask

  task automatic test_mac_seq();
    logic [W-1:0]  xs [3] = '{16'd2, 16'hFFFC, 16'd7};
    logic [W-1:0]  ys [3] = '{16'd3, 16'd5, 16'd7};
    logic [OW-1:0] ex [3] = '{32'h00000006, 32'hFFFFFFF2, 32'h00000023};
    logic [OW-1:0] acc_before;
    int lat;
    logic [OW-1:0] res;
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, xs[i], ys[i], (i == 0), lat, res);
      n_cmp++;
      if (res !== ex[i] || acc !== ex[i]) begin
        n_err++; $display("FAIL mac_seq[%0d]: result=%h acc=%h required %h", i, res, acc, ex[i]);
      end
      pop();
      acc_before = acc;
      in_valid = 1'b1; op = 2'b00;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (acc !== acc_before || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL mac_nop[%0d]: acc=%h out_valid=%b in_ready=%b required %h/0/1", i, acc, out_valid, in_ready, acc_before);
      end
    end
    m_acc = 32'h00000023;
  endtask

  task automatic test_back_to_back_backpressure();
    logic [W-1:0]  x, y;
    logic [OW-1:0] exp_res, res;
    int lat;
    x = W'($urandom); y = W'($urandom);
    issue(2'b10, x, y, 1'b0, lat, res);
    model_op(2'b10, x, y, 1'b0, exp_res);
    n_cmp++;
    if (res !== exp_res) begin n_err++; $display("FAIL bp_res: result=%h required %h", res, exp_res); end
    in_valid = 1'b1; op = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_res) begin
        n_err++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h required 1/0/%h", i, out_valid, in_ready, result, exp_res);
      end
    end
    in_valid = 1'b0;
    pop();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || acc !== m_acc) begin
      n_err++; $display("FAIL bp_after: out_valid=%b acc=%h required 0/%h", out_valid, acc, m_acc);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    in_valid = 1'b1; op = 2'b11; a = 16'd100; b = 16'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: busy=%b required 1", busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== '0 || acc !== '0) begin
      n_err++; $display("FAIL rst_mid_now: rdy/vld/busy=%b result=%h acc=%h required 100/0/0", {in_ready, out_valid, busy}, result, acc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_acc = '0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_mid_noresult: out_valid cycles=%0d required 0", seen); end
  endtask

  task automatic test_acc_clr_on_completion();
    logic [OW-1:0] exp_res, res;
    int lat;
    issue(2'b11, 16'd5, 16'd6, 1'b0, lat, res);
    model_op(2'b11, 16'd5, 16'd6, 1'b0, exp_res);
    pop();
    exp_res = m_acc + m_mul(16'd9, 16'hFFFD);
    in_valid = 1'b1; op = 2'b11; a = 16'd9; b = 16'hFFFD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_early: out_valid=%b required 0", out_valid); end
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== exp_res || acc !== '0) begin
      n_err++; $display("FAIL clr_complete: out_valid=%b result=%h acc=%h required 1/%h/0", out_valid, result, acc, exp_res);
    end
    pop();
    issue(2'b11, 16'd1, 16'd1, 1'b0, lat, res);
    model_op(2'b11, 16'd1, 16'd1, 1'b0, exp_res);
    n_cmp++;
    if (res !== exp_res || acc !== m_acc) begin
      n_err++; $display("FAIL clr_followup: result=%h acc=%h required %h/%h", res, acc, exp_res, m_acc);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_add_directed();
    test_random();
    test_mac_seq();
    test_back_to_back_backpressure();
    test_reset_mid_calc();
    test_acc_clr_on_completion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_r4_mac_unit.md
Name: booth_r4_mac_unit

Overview:
- Iterative signed radix-4 Booth arithmetic unit for the matrix datapath.
- Supports add, mult and a new multiply-accumulate (mac) mode.
- Operand width is parametrised; one Booth digit is retired per cycle.
- Sits between the operand fetch stage and the result collector, with valid/ready handshakes on both sides.

Parameters:
INWIDTH, 16, operand width in bits; must be even and >= 4.
OUTWIDTH, 2*INWIDTH, result and accumulator width (localparam, not overridable).
ITER, INWIDTH/2, number of Booth digits (localparam).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  2  00 nop, 01 add, 10 mult, 11 mac
a  input  INWIDTH  signed two's-complement operand (multiplicand)
b  input  INWIDTH  signed two's-complement operand (multiplier)
acc_clr  input  1  clear accumulator
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
result  output  OUTWIDTH  signed result
acc  output  OUTWIDTH  current accumulator value
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - in_ready=1, out_valid=0, result=0, acc=0, busy=0, state=IDLE.
  - All internal partial-product, shift and counter registers are cleared.
- Reset mid-operation aborts the operation; no result is produced.
- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on a clk edge with in_valid & in_ready.
  - op=nop: accepted and discarded; stays IDLE; no output.
  - op=add: result <= sext(a)+sext(b) to OUTWIDTH (cannot overflow); go to DONE.
  - op=mult or mac: latch a, b, op; clear partial product; counter=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, digit i examines {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Digit encoding (standard Booth): 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a.
  - The selected term is sign-extended to OUTWIDTH, shifted left by 2i, and added modulo 2^OUTWIDTH.
  - After ITER cycles (counter = ITER-1 processed), go to DONE and load result:
    - mult: result = product.
    - mac: result = acc + product, wrapping modulo 2^OUTWIDTH.
- mac accumulator update:
  - acc <= mac result on the same edge result is loaded.
- Latency, counted from the accept edge:
  - add: out_valid high after 1 edge.
  - mult/mac: out_valid high after ITER+1 edges (9 for INWIDTH=16).
- DONE:
  - out_valid=1, in_ready=0.
  - result is held stable until an edge with out_ready=1; then out_valid <= 0 and state goes to IDLE.
  - No new request is accepted in that same cycle; in_ready rises the following cycle.
- out_ready is ignored when out_valid=0.
- acc_clr:
  - Sampled every cycle in any state; acc <= 0 on the next edge.
  - If it coincides with the mac completion edge, the clear wins and the mac result is still presented on result.
  - If it coincides with a mac accept edge, the new mac uses acc=0.
- In-flight operations are unaffected by changes on a, b and op after the accept edge.
- Unsigned operands are out of scope; callers sign-extend.

Test Plan:
- INWIDTH=16, reset released, mult a=3, b=-5 -> out_valid rises 9 edges after accept; result=0xFFFFFFF1; acc unchanged at 0.
- mult a=-32768, b=-32768 -> result=0x40000000.
- mult a=0x7FFF, b=-32768 -> result=0xC0008000.
- add a=0x7FFF, b=0x7FFF -> out_valid after 1 edge; result=0x0000FFFE.
- add a=-1, b=-1 -> result=0xFFFFFFFE.
- Accumulation sequence: acc_clr, then mac(2,3), mac(-4,5), mac(7,7):
  - Results 6, -14 (0xFFFFFFF2), 35 (0x23).
  - acc=0x23 at the end.
  - nop between macs leaves acc and out_valid unchanged.
- Backpressure: hold out_ready=0 for 20 cycles after a mult completes -> out_valid and result stable, in_ready=0 throughout, and a second in_valid is not accepted. Release out_ready -> in_ready returns 1 cycle later.
- Boundary and reset cases:
  - Pulse reset_n low at CALC cycle 4 -> outputs immediately return to reset values and no out_valid appears.
  - acc_clr on the mac completion edge -> acc=0 and result=mac value.
